lsu_mem_ctrl: RTL and testbench

Load/store sequencing controller between the CPU's memory stage and a multicycle, word-organised data memory. It accepts one load or store request at a time, splits misaligned half/word accesses into two aligned word beats, and generates byte enables and lane-shifted write data. It assembles and sign/zero-extends load results using the same size encoding as the load-extend path. It stalls the CPU through `busy` until the single-cycle response.

---
 rtl/lsu_mem_ctrl_if.sv | 33 +++
 rtl/lsu_mem_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// CPU-side request/response and memory-side beat signals of the load/store controller.
// The controller takes the slave view; the CPU/memory environment takes the master view.
interface lsu_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_fault;
   logic        busy;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
      output req_ready, resp_valid, resp_data, resp_fault, busy,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
      input  req_ready, resp_valid, resp_data, resp_fault, busy,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: splits misaligned accesses into two aligned word beats,
// places store lanes, assembles/extends load data and times out stalled beats.
module lsu_mem_ctrl #(
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic          clk,
   input  logic          reset,
   lsu_mem_ctrl_if.slave bus
);
   localparam int CW = $clog2(WAIT_LIMIT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BEAT0 = 2'd1;
   localparam logic [1:0] S_BEAT1 = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic          we_q, we_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    off_q, off_d;
   logic          split_q, split_d;
   logic [31:0]   lo_q, lo_d;
   logic [3:0]    be_hi_q, be_hi_d;
   logic [31:0]   wd_hi_q, wd_hi_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic          resp_valid_q, resp_valid_d;
   logic [31:0]   resp_data_q, resp_data_d;
   logic          resp_fault_q, resp_fault_d;

   // Incoming request decode: size class, split decision and lane placement
   logic [1:0]  off_in;
   logic [3:0]  mask_base;
   logic [7:0]  mask8;
   logic [63:0] data64;
   logic        split_in, illegal_in;

   always_comb begin
      off_in     = bus.req_addr[1:0];
      mask_base  = 4'b0001;
      split_in   = 1'b0;
      case (bus.req_funct3)
         3'b001, 3'b100: begin
            mask_base = 4'b0011;
            split_in  = (off_in == 2'b11);
         end
         3'b010: begin
            mask_base = 4'b1111;
            split_in  = (off_in != 2'b00);
         end
         default: ;
      endcase
      illegal_in = bus.req_we ? (bus.req_funct3 > 3'd2) : (bus.req_funct3 > 3'd4);
      mask8      = {4'b0000, mask_base} << off_in;
      data64     = {32'b0, bus.req_wdata} << {off_in, 3'b000};
   end

   // Load assembly: {hi, lo} shifted right by the byte offset, then extended
   logic [63:0] asm64;
   logic [31:0] sh32, ext;

   always_comb begin
      asm64 = (state_q == S_BEAT1) ? {bus.mem_rdata, lo_q} : {32'b0, bus.mem_rdata};
      sh32  = asm64[{off_q, 3'b000} +: 32];
      case (f3_q)
         3'b000:  ext = {{24{sh32[7]}}, sh32[7:0]};
         3'b001:  ext = {{16{sh32[15]}}, sh32[15:0]};
         3'b011:  ext = {24'b0, sh32[7:0]};
         3'b100:  ext = {16'b0, sh32[15:0]};
         default: ext = sh32;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      f3_d         = f3_q;
      off_d        = off_q;
      split_d      = split_q;
      lo_d         = lo_q;
      be_hi_d      = be_hi_q;
      wd_hi_d      = wd_hi_q;
      cnt_d        = cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_data_d  = 32'b0;
      resp_fault_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               f3_d    = bus.req_funct3;
               off_d   = off_in;
               split_d = split_in;
               if (illegal_in) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
               end else begin
                  state_d     = S_BEAT0;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.req_we;
                  mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                  mem_be_d    = bus.req_we ? mask8[3:0] : 4'hF;
                  mem_wdata_d = bus.req_we ? data64[31:0] : 32'b0;
                  be_hi_d     = mask8[7:4];
                  wd_hi_d     = data64[63:32];
               end
            end
         end
         S_BEAT0, S_BEAT1: begin
            if (bus.mem_ack) begin
               cnt_d = '0;
               if (state_q == S_BEAT0) lo_d = bus.mem_rdata;
               if (state_q == S_BEAT0 && split_q) begin
                  // Second beat follows back-to-back with mem_req held high
                  state_d     = S_BEAT1;
                  mem_addr_d  = mem_addr_q + 32'd4;
                  mem_be_d    = we_q ? be_hi_q : 4'hF;
                  mem_wdata_d = we_q ? wd_hi_q : 32'b0;
               end else begin
                  state_d      = S_RESP;
                  mem_req_d    = 1'b0;
                  mem_we_d     = 1'b0;
                  mem_addr_d   = 32'b0;
                  mem_be_d     = 4'b0;
                  mem_wdata_d  = 32'b0;
                  resp_valid_d = 1'b1;
                  resp_data_d  = we_q ? 32'b0 : ext;
               end
            end else if (cnt_q == CW'(WAIT_LIMIT - 1)) begin
               state_d      = S_RESP;
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               mem_addr_d   = 32'b0;
               mem_be_d     = 4'b0;
               mem_wdata_d  = 32'b0;
               resp_valid_d = 1'b1;
               resp_fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         f3_q         <= 3'b0;
         off_q        <= 2'b0;
         split_q      <= 1'b0;
         lo_q         <= 32'b0;
         be_hi_q      <= 4'b0;
         wd_hi_q      <= 32'b0;
         cnt_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'b0;
         mem_be_q     <= 4'b0;
         mem_wdata_q  <= 32'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 32'b0;
         resp_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
         split_q      <= split_d;
         lo_q         <= lo_d;
         be_hi_q      <= be_hi_d;
         wd_hi_q      <= wd_hi_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_fault_q <= resp_fault_d;
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE) && !reset;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_fault = resp_fault_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a vector table of single requests with a
// zero-wait memory, plus hand sequences for reset, timeout and mid-access reset.
module tb_lsu_mem_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   lsu_mem_ctrl_if bus();

   lsu_mem_ctrl #(.WAIT_LIMIT(255)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic        flt;
      logic        split;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [3:0]  be0;
      logic [3:0]  be1;
      logic [31:0] wd0;
      logic [31:0] wd1;
      logic [31:0] data;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      chk({v.name, ".ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = v.we;
      bus.req_funct3 = v.f3;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (v.flt) begin
         chk({v.name, ".rvalid"}, 32'(bus.resp_valid), 32'd1);
         chk({v.name, ".fault"},  32'(bus.resp_fault), 32'd1);
         chk({v.name, ".data"},   bus.resp_data, 32'd0);
         chk({v.name, ".memreq"}, 32'(bus.mem_req), 32'd0);
      end else begin
         chk({v.name, ".memreq0"}, 32'(bus.mem_req), 32'd1);
         chk({v.name, ".busy"},    32'(bus.busy), 32'd1);
         chk({v.name, ".we"},      32'(bus.mem_we), 32'(v.we));
         chk({v.name, ".addr0"},   bus.mem_addr, v.a0);
         chk({v.name, ".be0"},     32'(bus.mem_be), 32'(v.be0));
         if (v.we) chk({v.name, ".wd0"}, bus.mem_wdata, v.wd0);
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = v.rd0;
         @(negedge clk);
         if (v.split) begin
            chk({v.name, ".memreq1"}, 32'(bus.mem_req), 32'd1);
            chk({v.name, ".rvalid_early"}, 32'(bus.resp_valid), 32'd0);
            chk({v.name, ".addr1"},   bus.mem_addr, v.a1);
            chk({v.name, ".be1"},     32'(bus.mem_be), 32'(v.be1));
            if (v.we) chk({v.name, ".wd1"}, bus.mem_wdata, v.wd1);
            bus.mem_rdata = v.rd1;
            @(negedge clk);
         end
         bus.mem_ack = 1'b0;
         chk({v.name, ".rvalid"}, 32'(bus.resp_valid), 32'd1);
         chk({v.name, ".fault"},  32'(bus.resp_fault), 32'd0);
         chk({v.name, ".data"},   bus.resp_data, v.data);
         chk({v.name, ".memreq"}, 32'(bus.mem_req), 32'd0);
      end
      @(negedge clk);
      chk({v.name, ".rvalid_off"}, 32'(bus.resp_valid), 32'd0);
      chk({v.name, ".ready_again"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      //              name    we  f3      addr           wdata          rd0            rd1            flt   split a0             a1             be0      be1      wd0            wd1            data
      vecs[0]  = '{"lb",      0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_1234, 32'h0,         1'b0, 1'b0, 32'h0000_1000, 32'h0,         4'hF,    4'h0,    32'h0,         32'h0,         32'hFFFF_FF80};
      vecs[1]  = '{"lw_spl",  0, 3'b010, 32'h0000_2002, 32'h0,         32'hAABB_CCDD, 32'h1122_3344, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_2004, 4'hF,    4'hF,    32'h0,         32'h0,         32'h3344_AABB};
      vecs[2]  = '{"sh_spl",  1, 3'b001, 32'h0000_3003, 32'h0000_BEEF, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_3000, 32'h0000_3004, 4'b1000, 4'b0001, 32'hEF00_0000, 32'h0000_00BE, 32'h0};
      vecs[3]  = '{"lw_wrap", 0, 3'b010, 32'hFFFF_FFFE, 32'h0,         32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF,    4'hF,    32'h0,         32'h0,         32'hDEF0_1234};
      vecs[4]  = '{"lhu",     0, 3'b100, 32'h0000_4000, 32'h0,         32'hABCD_F00D, 32'h0,         1'b0, 1'b0, 32'h0000_4000, 32'h0,         4'hF,    4'h0,    32'h0,         32'h0,         32'h0000_F00D};
      vecs[5]  = '{"lh_off2", 0, 3'b001, 32'h0000_4002, 32'h0,         32'h8001_0000, 32'h0,         1'b0, 1'b0, 32'h0000_4000, 32'h0,         4'hF,    4'h0,    32'h0,         32'h0,         32'hFFFF_8001};
      vecs[6]  = '{"lbu",     0, 3'b011, 32'h0000_6001, 32'h0,         32'h0000_9A00, 32'h0,         1'b0, 1'b0, 32'h0000_6000, 32'h0,         4'hF,    4'h0,    32'h0,         32'h0,         32'h0000_009A};
      vecs[7]  = '{"sw",      1, 3'b010, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_7000, 32'h0,         4'hF,    4'h0,    32'hDEAD_BEEF, 32'h0,         32'h0};
      vecs[8]  = '{"sb_off2", 1, 3'b000, 32'h0000_7002, 32'h1234_56A5, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_7000, 32'h0,         4'b0100, 4'h0,    32'h56A5_0000, 32'h0,         32'h0};
      vecs[9]  = '{"lh_spl",  0, 3'b001, 32'h0000_8003, 32'h0,         32'h3400_0000, 32'h0000_00F2, 1'b0, 1'b1, 32'h0000_8000, 32'h0000_8004, 4'hF,    4'hF,    32'h0,         32'h0,         32'hFFFF_F234};
      vecs[10] = '{"ld_ill",  0, 3'b101, 32'h0000_9000, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         4'h0,    4'h0,    32'h0,         32'h0,         32'h0};
      vecs[11] = '{"st_ill",  1, 3'b011, 32'h0000_9004, 32'h1,         32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         4'h0,    4'h0,    32'h0,         32'h0,         32'h0};
      vecs[12] = '{"sw_spl",  1, 3'b010, 32'h0000_A001, 32'h1122_3344, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_A000, 32'h0000_A004, 4'b1110, 4'b0001, 32'h2233_4400, 32'h0000_0011, 32'h0};

      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
      bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.ready_in_reset", 32'(bus.req_ready), 32'd0);
      chk("rst.memreq",  32'(bus.mem_req), 32'd0);
      chk("rst.addr",    bus.mem_addr, 32'd0);
      chk("rst.be",      32'(bus.mem_be), 32'd0);
      chk("rst.rvalid",  32'(bus.resp_valid), 32'd0);
      chk("rst.rdata",   bus.resp_data, 32'd0);
      chk("rst.busy",    32'(bus.busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst.ready_after", 32'(bus.req_ready), 32'd1);

      for (int i = 0; i < 13; i++) run_vec(vecs[i]);

      // Timeout: ack withheld, mem_req must stay up exactly 255 cycles
      begin
         int n;
         n = 0;
         @(negedge clk);
         bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b100; bus.req_addr = 32'h0000_5000;
         @(negedge clk);
         bus.req_valid = 1'b0;
         while (bus.mem_req && n < 1000) begin
            n++;
            @(negedge clk);
         end
         chk("tmo.req_cycles", 32'(n), 32'd255);
         chk("tmo.rvalid", 32'(bus.resp_valid), 32'd1);
         chk("tmo.fault",  32'(bus.resp_fault), 32'd1);
         chk("tmo.data",   bus.resp_data, 32'd0);
         @(negedge clk);
         chk("tmo.ready",  32'(bus.req_ready), 32'd1);
      end

      // Reset pulsed during BEAT1 of a split load
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h0000_2002;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAABB_CCDD;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("rmid.in_beat1", bus.mem_addr, 32'h0000_2004);
      reset = 1'b1;
      @(negedge clk);
      chk("rmid.memreq", 32'(bus.mem_req), 32'd0);
      chk("rmid.rvalid", 32'(bus.resp_valid), 32'd0);
      chk("rmid.ready_in_reset", 32'(bus.req_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rmid.ready", 32'(bus.req_ready), 32'd1);
      chk("rmid.rvalid_after", 32'(bus.resp_valid), 32'd0);
      chk("rmid.busy", 32'(bus.busy), 32'd0);

      // Post-reset request still works
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
